register_file: RTL and testbench
================================

# register_file

MIPS integer register file: the consumer of the writeback stage's register-write traffic and the source of decode-stage operands. It holds 32 x 32-bit architectural registers, with `$0` hardwired to zero. It accepts one write per cycle from writeback (`RegWriteW`, `WriteRegW`, `ResultW`) and serves two decode read ports plus one debug read port. A same-cycle write-to-read bypass replaces the classic falling-edge write, keeping the design single-edge.

## Interface
- `NREGS`, 32: number of architectural registers; fixed at 32 for MIPS.
- `WIDTH`, 32: register data width.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; clears all registers.
- `RegWriteW` input 1: write enable from writeback.
- `WriteRegW` input 5: destination register index from writeback.
- `ResultW` input 32: write data from writeback.
- `A1` input 5: decode read port 1 address (`rs`).
- `A2` input 5: decode read port 2 address (`rt`).
- `RD1` output 32: read data for `A1`.
- `RD2` output 32: read data for `A2`.
- `DbgA` input 5: debug/testbench read address.
- `DbgRD` output 32: debug read data, unbypassed.
- `WrCount` output 32: count of committed writes. Writes to `$0` and writes during reset are excluded.

## Operation
- Storage: registers 1..31 are flops; there is no storage for index 0.
- Write: on a rising edge with `reset`=0, `RegWriteW`=1 and `WriteRegW`!=0, `regs[WriteRegW]` <= `ResultW` and `WrCount` <= `WrCount`+1.
  - `WrCount` wraps modulo 2^32.
- Ignored write: if `WriteRegW`=0, the write is dropped and `WrCount` is unchanged.
- Reset: on a rising edge with `reset`=1, all of `regs[1..31]` <= 0 and `WrCount` <= 0.
  - Any concurrent write is discarded; reset dominates.
- Read ports (combinational), for port p in {1,2}:
  - If `Ap`=0, `RDp`=0.
  - Else if `reset`=0, `RegWriteW`=1 and `WriteRegW`=`Ap`, `RDp`=`ResultW` (bypass).
  - Else `RDp`=`regs[Ap]`.
- Reset and outputs: while `reset`=1, `RD1`, `RD2` and `DbgRD` are forced to 0, because a reset in progress invalidates the contents.
- Simultaneous events: both read ports may hit the bypass on the same write.
  - Both return `ResultW`.
- Debug port: `DbgRD` returns `regs[DbgA]` (0 for `DbgA`=0). It is never bypassed, so it shows committed state only.
- X handling: an X on `RegWriteW` while `reset`=0 is a verification error (assertion); the RTL does not mask it.

## Timing
- Write latency: visible on `RD1`/`RD2` in the same cycle via the bypass; visible on `DbgRD` one cycle after the edge.
- Read latency: 0 cycles; a purely combinational path from `A1`/`A2` to `RD1`/`RD2`.
- Reset values: all registers 0, `WrCount`=0, `RD1`/`RD2`/`DbgRD`=0 while `reset` is high.
  - After deassertion, every register reads 0 until written.
- Reset mid-stream: a write in the same cycle as reset is lost, and the bypass is suppressed in that cycle.
- No handshake: writeback asserts `RegWriteW` for exactly one cycle per instruction, and the block accepts every cycle with no backpressure.
- Critical path: `WriteRegW` compare -> bypass mux -> `RDp`. The decode comparator consumes `RDp` in the same cycle.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_ADDR_W`=5, `DATA_W`=32.
  - Constant `REG_ZERO`=5'd0.
  - Typedefs `reg_addr_t`, `word_t`.
  - This block, writeback, decode and the hazard unit all import it.
- One sub-module: `regfile_read_port`.
  - Inputs: address, storage vector, write enable/index/data, reset.
  - Output: read data.
  - Implements the zero/bypass/storage priority.
  - Instantiated twice, for `RD1` and `RD2`.
- The debug port is a plain indexed read in the top module.
- Top module holds the storage array, write logic and `WrCount`.

## Test plan
- Reset then sweep:
  - Stimulus: reset 2 cycles, then `DbgA`=0..31.
  - Required: every `DbgRD`=0 and `WrCount`=0.
- Basic write/read:
  - Stimulus: write `ResultW`=0xDEADBEEF to `WriteRegW`=8, then the next cycle `A1`=8.
  - Required: `RD1`=0xDEADBEEF and `WrCount`=1.
- Same-cycle bypass:
  - Stimulus: `RegWriteW`=1, `WriteRegW`=17, `ResultW`=0x12345678, `A1`=`A2`=17; `regs[17]` previously held 0xAAAA0000.
  - Required: `RD1`=`RD2`=0x12345678 and `DbgRD`(17)=0xAAAA0000 in that cycle; `DbgRD`=0x12345678 the next cycle.
- `$0` immutability:
  - Stimulus: write 0xFFFFFFFF to index 0, then read `A1`=0, plus a same-cycle bypass attempt on index 0.
  - Required: `RD1`=0 and `WrCount` unchanged.
- Reset mid-operation:
  - Stimulus: fill `regs[1..31]` with index*0x01010101, then assert `reset` in the same cycle as a write of 0x55 to `WriteRegW`=3 with `A1`=3.
  - Required: `RD1`=0 that cycle; after reset every register reads 0 and `WrCount`=0.
- Back-to-back writes and wrap:
  - Stimulus: 31 consecutive writes to indices 1..31; then write the same index twice in consecutive cycles.
  - Required: the last value wins and `WrCount` increments every cycle.
  - Wrap: force `WrCount` to 0xFFFFFFFF via a hierarchical deposit, then perform one more write; required `WrCount`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register address/data widths and the
// hardwired-zero register index. Imported by the register file, writeback,
// decode and the hazard unit.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_read_port.sv
// One combinational register-file read port. Priority, highest first:
// reset in progress, $0, same-cycle writeback bypass, committed storage.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int WIDTH = DATA_W
) (
  input  logic                        reset,
  input  reg_addr_t                   addr,
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic                        we,
  input  reg_addr_t                   waddr,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rd
);

  logic [WIDTH-1:0] rd_s;

  // Select read data: the bypass lets decode see this cycle's writeback value.
  always_comb begin
    rd_s = {WIDTH{1'b0}};
    if (reset) begin
      rd_s = {WIDTH{1'b0}};
    end else if (addr == REG_ZERO) begin
      rd_s = {WIDTH{1'b0}};
    end else if (we && (waddr == addr)) begin
      rd_s = wdata;
    end else begin
      rd_s = regs[addr];
    end
  end

  assign rd = rd_s;

endmodule : regfile_read_port

// File: rtl/register_file_checker.sv
// Protocol checks for the register file's writeback inputs.
module register_file_checker (
  input logic clk,
  input logic reset,
  input logic RegWriteW
);

  // Write enable must be a known value whenever the file is not in reset.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(RegWriteW));
    end else begin
      assert (1'b1);
    end
  end

endmodule : register_file_checker

// File: rtl/register_file.sv
// MIPS 32x32 integer register file with $0 hardwired to zero, one writeback
// write port, two bypassed decode read ports, an unbypassed debug read port
// and a committed-write counter.
module register_file
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteW,
  input  reg_addr_t        WriteRegW,
  input  logic [WIDTH-1:0] ResultW,
  input  reg_addr_t        A1,
  input  reg_addr_t        A2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  input  reg_addr_t        DbgA,
  output logic [WIDTH-1:0] DbgRD,
  output logic [31:0]      WrCount
);

  // Only registers 1..NREGS-1 have flops; index 0 is a constant zero.
  logic [NREGS-1:1][WIDTH-1:0] regs_r;
  logic [NREGS-1:0][WIDTH-1:0] regs_view_s;
  logic [31:0]                 wrcount_r;
  logic                        commit_s;
  logic [WIDTH-1:0]            dbg_rd_s;

  assign regs_view_s = {regs_r, {WIDTH{1'b0}}};
  assign commit_s    = RegWriteW && (WriteRegW != REG_ZERO);

  // Storage update: reset clears everything and discards a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (commit_s) begin
      for (int i = 1; i < NREGS; i++) begin
        if (WriteRegW == i[REG_ADDR_W-1:0]) begin
          regs_r[i] <= ResultW;
        end
      end
    end
  end

  // Count committed writes; $0 writes and writes under reset do not count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrcount_r <= 32'd0;
    end else if (commit_s) begin
      wrcount_r <= wrcount_r + 32'd1;
    end
  end

  // Debug read shows committed state only, never the bypass.
  always_comb begin
    dbg_rd_s = {WIDTH{1'b0}};
    if (reset) begin
      dbg_rd_s = {WIDTH{1'b0}};
    end else begin
      dbg_rd_s = regs_view_s[DbgA];
    end
  end

  regfile_read_port #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rp1 (
    .reset (reset),
    .addr  (A1),
    .regs  (regs_view_s),
    .we    (RegWriteW),
    .waddr (WriteRegW),
    .wdata (ResultW),
    .rd    (RD1)
  );

  regfile_read_port #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rp2 (
    .reset (reset),
    .addr  (A2),
    .regs  (regs_view_s),
    .we    (RegWriteW),
    .waddr (WriteRegW),
    .wdata (ResultW),
    .rd    (RD2)
  );

  register_file_checker u_chk (
    .clk       (clk),
    .reset     (reset),
    .RegWriteW (RegWriteW)
  );

  assign DbgRD   = dbg_rd_s;
  assign WrCount = wrcount_r;

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: behavioural array model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_register_file;

  bit          clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [4:0]  A1, A2, DbgA;
  logic [31:0] RD1, RD2, DbgRD, WrCount;

  logic [31:0] mregs [32];
  logic [31:0] mcount;
  int          vectors = 0;
  int          miscompares = 0;

  register_file dut (
    .clk       (clk),
    .reset     (reset),
    .RegWriteW (RegWriteW),
    .WriteRegW (WriteRegW),
    .ResultW   (ResultW),
    .A1        (A1),
    .A2        (A2),
    .RD1       (RD1),
    .RD2       (RD2),
    .DbgA      (DbgA),
    .DbgRD     (DbgRD),
    .WrCount   (WrCount)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_rd(logic [4:0] a);
    if (reset) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && WriteRegW == a) return ResultW;
    return mregs[a];
  endfunction

  task automatic drive(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] a1, logic [4:0] a2, logic [4:0] da);
    reset = rst; RegWriteW = we; WriteRegW = wa; ResultW = wd;
    A1 = a1; A2 = a2; DbgA = da;
  endtask

  // Let combinational outputs settle, then compare against the model.
  task automatic settle();
    #1;
    chk("RD1", RD1, model_rd(A1));
    chk("RD2", RD2, model_rd(A2));
    chk("DbgRD", DbgRD, reset ? 32'd0 : mregs[DbgA]);
    chk("WrCount", WrCount, mcount);
  endtask

  // Advance one clock and apply the architectural update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcount = 32'd0;
    end else if (RegWriteW && WriteRegW != 5'd0) begin
      mregs[WriteRegW] = ResultW;
      mcount = mcount + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcount = 32'd0;
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);

    // Reset for two cycles, then sweep the debug port.
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 5'd4, 32'h0BAD_F00D, 5'd4, 5'd4, 5'd4);
      settle();
      chk("rst_rd1", RD1, 32'd0);
      tick();
    end
    for (int d = 0; d < 32; d++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'(d));
      settle();
      chk("sweep_dbg", DbgRD, 32'd0);
      chk("sweep_cnt", WrCount, 32'd0);
      tick();
    end

    // Basic write then read.
    drive(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd8);
    settle();
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd8);
    settle();
    chk("basic_rd1", RD1, 32'hDEAD_BEEF);
    chk("basic_cnt", WrCount, 32'd1);
    tick();

    // Same-cycle bypass on both ports; debug port shows the old value.
    drive(1'b0, 1'b1, 5'd17, 32'hAAAA_0000, 5'd0, 5'd0, 5'd0);
    settle();
    tick();
    drive(1'b0, 1'b1, 5'd17, 32'h1234_5678, 5'd17, 5'd17, 5'd17);
    settle();
    chk("byp_rd1", RD1, 32'h1234_5678);
    chk("byp_rd2", RD2, 32'h1234_5678);
    chk("byp_dbg_old", DbgRD, 32'hAAAA_0000);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd17, 5'd0, 5'd17);
    settle();
    chk("byp_dbg_new", DbgRD, 32'h1234_5678);
    tick();

    // $0 is immutable and never bypassed.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    settle();
    chk("zero_byp_rd1", RD1, 32'd0);
    chk("zero_byp_rd2", RD2, 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    settle();
    chk("zero_rd1", RD1, 32'd0);
    chk("zero_cnt", WrCount, 32'd3);
    tick();

    // Fill, then reset concurrent with a write to $3.
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 1'b1, 5'(r), r * 32'h0101_0101, 5'(r), 5'd0, 5'd0);
      settle();
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd31, 5'd31);
    settle();
    chk("fill_rd1", RD1, 32'h0303_0303);
    chk("fill_dbg", DbgRD, 32'h1F1F_1F1F);
    tick();
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd3, 5'd3);
    settle();
    chk("midrst_rd1", RD1, 32'd0);
    tick();
    for (int d = 0; d < 32; d++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(d), 5'(31 - d), 5'(d));
      settle();
      chk("postrst_dbg", DbgRD, 32'd0);
      chk("postrst_rd1", RD1, 32'd0);
      chk("postrst_cnt", WrCount, 32'd0);
      tick();
    end

    // Back-to-back writes to every index, then the same index twice.
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 1'b1, 5'(r), $urandom, 5'(r), 5'(r - 1), 5'(r));
      settle();
      tick();
    end
    drive(1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd5, 5'd5, 5'd5);
    settle();
    chk("b2b_cnt31", WrCount, 32'd31);
    tick();
    drive(1'b0, 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd5, 5'd5);
    settle();
    chk("b2b_dbg_first", DbgRD, 32'h1111_1111);
    chk("b2b_cnt32", WrCount, 32'd32);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);
    settle();
    chk("b2b_last_wins", DbgRD, 32'h2222_2222);
    chk("b2b_cnt33", WrCount, 32'd33);
    tick();

    // Counter wrap via hierarchical deposit.
    dut.wrcount_r = 32'hFFFF_FFFF;
    mcount = 32'hFFFF_FFFF;
    drive(1'b0, 1'b1, 5'd9, 32'h0000_0009, 5'd9, 5'd0, 5'd9);
    settle();
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 5'd9);
    settle();
    chk("wrap_cnt", WrCount, 32'd0);
    tick();

    // Randomized traffic with occasional reset and biased address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) < 3),
            1'($urandom),
            wa,
            $urandom,
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file
